// File: rtl/e3_pkg.sv
// ------------------------------------------------------------------
// e3_pkg : shared state type and excess-3 code constants
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package e3_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } e3_state_t;

  // Bit i of the offset is the subtrahend bit used while in state Si.
  localparam logic [3:0] E3_OFFSET = 4'b0011;
  localparam int unsigned E3_MIN = 3;
  localparam int unsigned E3_MAX = 12;

endpackage

`default_nettype wire

// File: rtl/serial_sub_cell.sv
// ------------------------------------------------------------------
// serial_sub_cell : 1-bit full subtractor (a - k - borrow_in)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module serial_sub_cell (
  input  logic a_i,
  input  logic k_i,
  input  logic borrow_i,
  output logic r_o,
  output logic borrow_o
);

  assign r_o      = a_i ^ k_i ^ borrow_i;
  assign borrow_o = (~a_i & (k_i | borrow_i)) | (k_i & borrow_i);

endmodule

`default_nettype wire

// File: rtl/excess3_to_bcd_serial.sv
// ------------------------------------------------------------------
// excess3_to_bcd_serial : LSB-first serial excess-3 to BCD converter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module excess3_to_bcd_serial
  import e3_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_clr,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             out_valid,
  output logic             out_bit,
  output logic             digit_valid,
  output logic [3:0]       digit,
  output logic             digit_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  e3_state_t        state_q, state_d;
  logic             borrow_q, borrow_d;
  logic [2:0]       res_q, res_d;
  logic [2:0]       raw_q, raw_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic             digit_valid_q, digit_valid_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_err_q, digit_err_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic             w_k;
  logic             w_r;
  logic             w_bout;
  logic             w_err;

  assign w_k = E3_OFFSET[state_q];

  serial_sub_cell u_sub (
    .a_i      (in_bit),
    .k_i      (w_k),
    .borrow_i (borrow_q),
    .r_o      (w_r),
    .borrow_o (w_bout)
  );

  // Final borrow flags codes below the minimum; the raw compare catches 1101..1111.
  assign w_err = w_bout | ({in_bit, raw_q} > 4'(E3_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S0;
      borrow_q      <= 1'b0;
      res_q         <= 3'b000;
      raw_q         <= 3'b000;
      out_valid_q   <= 1'b0;
      out_bit_q     <= 1'b0;
      digit_valid_q <= 1'b0;
      digit_q       <= 4'b0000;
      digit_err_q   <= 1'b0;
      good_q        <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      borrow_q      <= borrow_d;
      res_q         <= res_d;
      raw_q         <= raw_d;
      out_valid_q   <= out_valid_d;
      out_bit_q     <= out_bit_d;
      digit_valid_q <= digit_valid_d;
      digit_q       <= digit_d;
      digit_err_q   <= digit_err_d;
      good_q        <= good_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    borrow_d      = borrow_q;
    res_d         = res_q;
    raw_d         = raw_q;
    out_valid_d   = 1'b0;
    out_bit_d     = out_bit_q;
    digit_valid_d = 1'b0;
    digit_d       = digit_q;
    digit_err_d   = digit_err_q;
    good_d        = good_q;
    err_d         = err_q;

    if (sync_clr) begin
      state_d  = S0;
      borrow_d = 1'b0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      out_bit_d   = w_r;
      res_d       = {w_r, res_q[2:1]};
      raw_d       = {in_bit, raw_q[2:1]};
      borrow_d    = w_bout;
      case (state_q)
        S0: state_d = S1;
        S1: state_d = S2;
        S2: state_d = S3;
        S3: begin
          state_d       = S0;
          borrow_d      = 1'b0;
          digit_d       = {w_r, res_q};
          digit_err_d   = w_err;
          digit_valid_d = 1'b1;
          if (w_err) begin
            if (err_q != '1) err_d = err_q + 1'b1;
          end else begin
            if (good_q != '1) good_d = good_q + 1'b1;
          end
        end
        default: state_d = S0;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_bit     = out_bit_q;
  assign digit_valid = digit_valid_q;
  assign digit       = digit_q;
  assign digit_err   = digit_err_q;
  assign good_cnt    = good_q;
  assign err_cnt     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_excess3_to_bcd_serial.sv
// ------------------------------------------------------------------
// tb_excess3_to_bcd_serial : directed self-checking bench
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_excess3_to_bcd_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;

  logic       out_valid, out_bit, digit_valid, digit_err;
  logic [3:0] digit;
  logic [7:0] good_cnt, err_cnt;

  logic       out_valid2, out_bit2, digit_valid2, digit_err2;
  logic [3:0] digit2;
  logic [1:0] good_cnt2, err_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  excess3_to_bcd_serial dut (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .in_valid(in_valid), .in_bit(in_bit),
    .out_valid(out_valid), .out_bit(out_bit), .digit_valid(digit_valid),
    .digit(digit), .digit_err(digit_err), .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  excess3_to_bcd_serial #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .in_valid(in_valid), .in_bit(in_bit),
    .out_valid(out_valid2), .out_bit(out_bit2), .digit_valid(digit_valid2),
    .digit(digit2), .digit_err(digit_err2), .good_cnt(good_cnt2), .err_cnt(err_cnt2)
  );

  task automatic drive_bit(input logic b);
    @(negedge clk);
    sync_clr = 1'b0;
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [3:0] code, input logic [3:0] exp_digit,
                           input logic exp_err, input string name);
    for (int i = 0; i < 4; i++) begin
      drive_bit(code[i]);
      checks++;
      if (out_valid !== 1'b1 || out_bit !== exp_digit[i] || digit_valid !== (i == 3)) begin
        errors++;
        $display("FAIL %s bit%0d: got ov=%b ob=%b dv=%b, want ov=1 ob=%b dv=%b",
                 name, i, out_valid, out_bit, digit_valid, exp_digit[i], (i == 3));
      end
    end
    checks++;
    if (digit !== exp_digit || digit_err !== exp_err) begin
      errors++;
      $display("FAIL %s digit: got %b err=%b, want %b err=%b",
               name, digit, digit_err, exp_digit, exp_err);
    end
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || digit_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s idle%0d: got ov=%b dv=%b, want 0 0", name, i, out_valid, digit_valid);
      end
    end
  endtask

  task automatic check_cnt(input logic [7:0] eg, input logic [7:0] ee, input string name);
    checks++;
    if (good_cnt !== eg || err_cnt !== ee) begin
      errors++;
      $display("FAIL %s counters: got good=%0d err=%0d, want good=%0d err=%0d",
               name, good_cnt, err_cnt, eg, ee);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({out_valid, out_bit, digit_valid, digit, digit_err, good_cnt, err_cnt} !== '0 ||
        {out_valid2, out_bit2, digit_valid2, digit2, digit_err2, good_cnt2, err_cnt2} !== '0) begin
      errors++;
      $display("FAIL %s: got ov=%b ob=%b dv=%b d=%b de=%b g=%0d e=%0d, want all 0",
               name, out_valid, out_bit, digit_valid, digit, digit_err, good_cnt, err_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_code(4'b1000, 4'b0101, 1'b0, "code1000");
    check_cnt(8'd1, 8'd0, "code1000");
  endtask

  task automatic test_back_to_back();
    send_code(4'b0011, 4'b0000, 1'b0, "code0011");
    send_code(4'b1100, 4'b1001, 1'b0, "code1100");
    check_cnt(8'd3, 8'd0, "b2b");
  endtask

  task automatic test_errors();
    send_code(4'b0001, 4'b1110, 1'b1, "code0001");
    check_cnt(8'd3, 8'd1, "err1");
    send_code(4'b1111, 4'b1100, 1'b1, "code1111");
    check_cnt(8'd3, 8'd2, "err2");
  endtask

  task automatic test_gaps();
    logic [3:0] code;
    logic [3:0] expd;
    code = 4'b0111;
    expd = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      idle(3, "gaps");
      drive_bit(code[i]);
      checks++;
      if (out_valid !== 1'b1 || out_bit !== expd[i] || digit_valid !== (i == 3)) begin
        errors++;
        $display("FAIL gaps bit%0d: got ov=%b ob=%b dv=%b, want ov=1 ob=%b dv=%b",
                 i, out_valid, out_bit, digit_valid, expd[i], (i == 3));
      end
    end
    checks++;
    if (digit !== expd || digit_err !== 1'b0) begin
      errors++;
      $display("FAIL gaps digit: got %b err=%b, want %b err=0", digit, digit_err, expd);
    end
    idle(1, "gaps_tail");
    check_cnt(8'd4, 8'd2, "gaps");
  endtask

  task automatic test_sync_clr();
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(negedge clk);
    sync_clr = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || digit_valid !== 1'b0 || digit !== 4'b0100) begin
      errors++;
      $display("FAIL sync_clr cycle: got ov=%b dv=%b d=%b, want ov=0 dv=0 d=0100",
               out_valid, digit_valid, digit);
    end
    check_cnt(8'd4, 8'd2, "sync_clr_hold");
    send_code(4'b1010, 4'b0111, 1'b0, "after_clr");
    check_cnt(8'd5, 8'd2, "after_clr");
  endtask

  task automatic test_async_reset();
    drive_bit(1'b1);
    drive_bit(1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_code(4'b0100, 4'b0001, 1'b0, "post_reset");
    check_cnt(8'd1, 8'd0, "post_reset");
  endtask

  task automatic test_saturation();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      send_code(4'b0101, 4'b0010, 1'b0, "sat");
    end
    check_cnt(8'd5, 8'd0, "sat_wide");
    checks++;
    if (good_cnt2 !== 2'd3 || err_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL sat_cntw2: got good=%0d err=%0d, want good=3 err=0", good_cnt2, err_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_errors();
    test_gaps();
    test_sync_clr();
    test_async_reset();
    test_saturation();
    idle(2, "final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
